// File: rtl/instruction_fetch_responder.sv
// rtl/instruction_fetch_responder.sv - memory-side responder returning 8-byte instruction lines after a fixed latency
//
// Ports:
//   clk                  single clock, all state on the rising edge
//   reset                asynchronous active-low reset of all control state
//   instructionRequest   level request from the cache controller, held until served
//   instructionAddress   byte address of the missing instruction, [31:3] selects the line
//   receivedInstruction  one-cycle response pulse
//   fetchedData          {word at base + 4, word at base}, zero outside the pulse
//   responderBusy        high whenever the FSM is not idle
//   servedCount          responses delivered since reset, wrapping
//   loadEnable           write strobe for the instruction store
//   loadAddress          byte address of the word to write, [1:0] ignored
//   loadData             word to write
module instruction_fetch_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instructionRequest,
    input  logic [31:0] instructionAddress,
    output logic        receivedInstruction,
    output logic [63:0] fetchedData,
    output logic        responderBusy,
    output logic [15:0] servedCount,
    input  logic        loadEnable,
    input  logic [31:0] loadAddress,
    input  logic [31:0] loadData
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATENCY,
        S_READ_LO,
        S_READ_HI,
        S_RESPOND
    } state_t;

    state_t        state;
    logic [31:0]   store [DEPTH_WORDS];
    logic [AW-1:0] line_base;
    logic [3:0]    lat_cnt;
    logic [31:0]   lo_reg;
    logic [31:0]   hi_reg;

    logic [AW-1:0] req_word;
    logic [AW-1:0] load_word;
    logic [AW-1:0] hi_idx;
    logic          unused_addr_bits;

    // Address bits above the store size alias; the low byte-offset bits are don't-care.
    assign req_word  = instructionAddress[AW+1:2];
    assign load_word = loadAddress[AW+1:2];
    assign hi_idx    = line_base | AW'(1);
    assign unused_addr_bits = ^{instructionAddress[31:AW+2], instructionAddress[1:0],
                                loadAddress[31:AW+2], loadAddress[1:0]};

    // Data is only presented during the response pulse.
    assign fetchedData = receivedInstruction ? {hi_reg, lo_reg} : 64'd0;

    // Image store: no reset, so contents survive a responder reset. A read on the
    // same edge as a write to that word sees the old contents (NBA ordering).
    always_ff @(posedge clk) begin
        if (loadEnable) begin
            store[load_word] <= loadData;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state               <= S_IDLE;
            line_base           <= '0;
            lat_cnt             <= 4'd0;
            lo_reg              <= 32'd0;
            hi_reg              <= 32'd0;
            receivedInstruction <= 1'b0;
            responderBusy       <= 1'b0;
            servedCount         <= 16'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (instructionRequest) begin
                        line_base     <= req_word & ~AW'(1);
                        responderBusy <= 1'b1;
                        lat_cnt       <= LAT_INIT;
                        if (LATENCY > 0) begin
                            state <= S_LATENCY;
                        end else begin
                            state <= S_READ_LO;
                        end
                    end
                end
                S_LATENCY: begin
                    if (!instructionRequest) begin
                        state         <= S_IDLE;
                        responderBusy <= 1'b0;
                    end else if (lat_cnt == 4'd0) begin
                        state <= S_READ_LO;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                S_READ_LO: begin
                    if (!instructionRequest) begin
                        state         <= S_IDLE;
                        responderBusy <= 1'b0;
                    end else begin
                        lo_reg <= store[line_base];
                        state  <= S_READ_HI;
                    end
                end
                S_READ_HI: begin
                    if (!instructionRequest) begin
                        state         <= S_IDLE;
                        responderBusy <= 1'b0;
                    end else begin
                        hi_reg              <= store[hi_idx];
                        receivedInstruction <= 1'b1;
                        state               <= S_RESPOND;
                    end
                end
                S_RESPOND: begin
                    // Committed: completes regardless of the request level.
                    receivedInstruction <= 1'b0;
                    responderBusy       <= 1'b0;
                    servedCount         <= servedCount + 16'd1;
                    state               <= S_IDLE;
                end
                default: begin
                    receivedInstruction <= 1'b0;
                    responderBusy       <= 1'b0;
                    state               <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_responder.sv
// tb/tb_instruction_fetch_responder.sv - self-checking bench for instruction_fetch_responder
module tb_instruction_fetch_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_a, req_b;
    logic [31:0] addr_a, addr_b;
    logic        rx_a, rx_b;
    logic [63:0] fd_a, fd_b;
    logic        busy_a, busy_b;
    logic [15:0] cnt_a, cnt_b;
    logic        load_en;
    logic [31:0] load_addr, load_data;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem_model [1024];
    int          exp_cnt [2];

    typedef struct {
        int          idx;
        logic [31:0] addr;
        int          cyc;
        logic [63:0] data;
    } vec_t;
    vec_t vecs [6];

    always #5 clk = ~clk;

    // Unit a: default latency 4. Unit b: latency 0. Both share reset and the load port.
    instruction_fetch_responder #(.DEPTH_WORDS(1024), .LATENCY(4)) dut_a (
        .clk(clk), .reset(reset),
        .instructionRequest(req_a), .instructionAddress(addr_a),
        .receivedInstruction(rx_a), .fetchedData(fd_a),
        .responderBusy(busy_a), .servedCount(cnt_a),
        .loadEnable(load_en), .loadAddress(load_addr), .loadData(load_data)
    );

    instruction_fetch_responder #(.DEPTH_WORDS(1024), .LATENCY(0)) dut_b (
        .clk(clk), .reset(reset),
        .instructionRequest(req_b), .instructionAddress(addr_b),
        .receivedInstruction(rx_b), .fetchedData(fd_b),
        .responderBusy(busy_b), .servedCount(cnt_b),
        .loadEnable(load_en), .loadAddress(load_addr), .loadData(load_data)
    );

    function automatic logic rx_of(input int idx);
        return (idx != 0) ? rx_b : rx_a;
    endfunction
    function automatic logic [63:0] fd_of(input int idx);
        return (idx != 0) ? fd_b : fd_a;
    endfunction
    function automatic logic busy_of(input int idx);
        return (idx != 0) ? busy_b : busy_a;
    endfunction
    function automatic logic [15:0] cnt_of(input int idx);
        return (idx != 0) ? cnt_b : cnt_a;
    endfunction
    function automatic int lat_of(input int idx);
        return (idx != 0) ? 0 : 4;
    endfunction

    // Expected 64-bit line from the reference image: low word at the even word index.
    function automatic logic [63:0] model_line(input logic [31:0] a);
        int base;
        base = int'(a[11:3]) * 2;
        return {mem_model[base + 1], mem_model[base]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_req(input int idx, input logic v, input logic [31:0] a);
        if (idx != 0) begin
            req_b  = v;
            addr_b = a;
        end else begin
            req_a  = v;
            addr_a = a;
        end
    endtask

    task automatic load_word(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        @(negedge clk);
        load_en = 1'b0;
        mem_model[a[11:2]] = d;
    endtask

    // Raise a request in cycle 0, wait for the pulse, drop the request in the response cycle.
    task automatic run_req(input int idx, input logic [31:0] a, input int exp_cyc,
                           input logic [63:0] exp_data, input string name);
        bit got;
        got = 1'b0;
        @(negedge clk);
        set_req(idx, 1'b1, a);
        for (int k = 1; k <= 30 && !got; k++) begin
            @(negedge clk);
            if (k == 1) chk({name, " busy"}, 64'(busy_of(idx)), 64'd1);
            if (rx_of(idx)) begin
                got = 1'b1;
                chk({name, " cycle"}, 64'(k), 64'(exp_cyc));
                chk({name, " data"}, fd_of(idx), exp_data);
                set_req(idx, 1'b0, a);
            end
        end
        if (!got) begin
            chk({name, " timeout"}, 64'd0, 64'd1);
            set_req(idx, 1'b0, a);
        end
        exp_cnt[idx]++;
        @(negedge clk);
        chk({name, " pulse width"}, 64'(rx_of(idx)), 64'd0);
        chk({name, " data idle"}, fd_of(idx), 64'd0);
        chk({name, " count"}, 64'(cnt_of(idx)), 64'(16'(exp_cnt[idx])));
    endtask

    initial begin
        int          p1, p2, pulses, pk, idx, lat, kab;
        bit          abort;
        logic [63:0] d1, d2, pd;
        logic [31:0] a;

        reset = 1'b0;
        req_a = 1'b0; req_b = 1'b0;
        addr_a = 32'd0; addr_b = 32'd0;
        load_en = 1'b0; load_addr = 32'd0; load_data = 32'd0;
        exp_cnt[0] = 0; exp_cnt[1] = 0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("reset rx_a", 64'(rx_a), 64'd0);
        chk("reset fd_a", fd_a, 64'd0);
        chk("reset busy_a", 64'(busy_a), 64'd0);
        chk("reset cnt_a", 64'(cnt_a), 64'd0);
        chk("reset rx_b", 64'(rx_b), 64'd0);
        chk("reset cnt_b", 64'(cnt_b), 64'd0);
        reset = 1'b1;

        // Preload the whole image with a recognisable pattern
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            load_en   = 1'b1;
            load_addr = 32'(i * 4);
            load_data = {16'hC0DE, 16'(i)};
            mem_model[i] = {16'hC0DE, 16'(i)};
        end
        @(negedge clk);
        load_en = 1'b0;

        // Basic refill
        load_word(32'h0000_0100, 32'h0050_0093);
        load_word(32'h0000_0104, 32'h00A0_0113);
        run_req(0, 32'h0000_0104, 7, 64'h00A00113_00500093, "basic");

        // Zero latency
        run_req(1, 32'h0000_0008, 3, {32'hC0DE_0003, 32'hC0DE_0002}, "lat0");

        // Abort in cycle 2, then a normal request
        @(negedge clk);
        set_req(0, 1'b1, 32'h0000_0010);
        repeat (2) @(negedge clk);
        set_req(0, 1'b0, 32'h0000_0010);
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (rx_a) pulses++;
        end
        chk("abort no pulse", 64'(pulses), 64'd0);
        chk("abort busy", 64'(busy_a), 64'd0);
        chk("abort count", 64'(cnt_a), 64'(16'(exp_cnt[0])));
        run_req(0, 32'h0000_0010, 7, {32'hC0DE_0005, 32'hC0DE_0004}, "after abort");

        // Back-to-back: request held through the response cycle
        @(negedge clk);
        set_req(0, 1'b1, 32'h0000_0018);
        p1 = -1; p2 = -1; d1 = '0; d2 = '0;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (rx_a) begin
                if (p1 < 0) begin
                    p1 = k; d1 = fd_a;
                end else if (p2 < 0) begin
                    p2 = k; d2 = fd_a;
                    set_req(0, 1'b0, 32'h0000_0018);
                end
            end
        end
        set_req(0, 1'b0, 32'h0000_0018);
        exp_cnt[0] += 2;
        chk("b2b first cycle", 64'(p1), 64'd7);
        chk("b2b second cycle", 64'(p2), 64'd15);
        chk("b2b first data", d1, {32'hC0DE_0007, 32'hC0DE_0006});
        chk("b2b second data", d2, {32'hC0DE_0007, 32'hC0DE_0006});
        chk("b2b count", 64'(cnt_a), 64'(16'(exp_cnt[0])));

        // Reset asserted in cycle 5
        @(negedge clk);
        set_req(0, 1'b1, 32'h0000_0010);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        set_req(0, 1'b0, 32'h0000_0010);
        #1;
        exp_cnt[0] = 0; exp_cnt[1] = 0;
        chk("midreset busy", 64'(busy_a), 64'd0);
        chk("midreset rx", 64'(rx_a), 64'd0);
        chk("midreset data", fd_a, 64'd0);
        chk("midreset count", 64'(cnt_a), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (rx_a) pulses++;
        end
        chk("midreset no pulse", 64'(pulses), 64'd0);

        // Table-driven vectors: aliasing, ignored offset bits, store kept through reset
        vecs[0] = '{0, 32'h0000_1000, 7, {32'hC0DE_0001, 32'hC0DE_0000}};
        vecs[1] = '{1, 32'h0000_0008, 3, {32'hC0DE_0003, 32'hC0DE_0002}};
        vecs[2] = '{0, 32'h0000_0010, 7, {32'hC0DE_0005, 32'hC0DE_0004}};
        vecs[3] = '{1, 32'h0000_0107, 3, 64'h00A00113_00500093};
        vecs[4] = '{0, 32'hFFFF_F018, 7, {32'hC0DE_0007, 32'hC0DE_0006}};
        vecs[5] = '{0, 32'h0000_0100, 7, 64'h00A00113_00500093};
        for (int v = 0; v < 6; v++) begin
            run_req(vecs[v].idx, vecs[v].addr, vecs[v].cyc, vecs[v].data, $sformatf("vec%0d", v));
        end

        // Load collision: write word 2 on the READ_LO edge of a zero-latency request to 0x8
        @(negedge clk);
        set_req(1, 1'b1, 32'h0000_0008);
        @(negedge clk);
        load_en = 1'b1; load_addr = 32'h0000_0008; load_data = 32'hDEAD_BEEF;
        @(negedge clk);
        load_en = 1'b0;
        @(negedge clk);
        chk("collision pulse", 64'(rx_b), 64'd1);
        chk("collision old data", fd_b, {32'hC0DE_0003, 32'hC0DE_0002});
        set_req(1, 1'b0, 32'h0000_0008);
        exp_cnt[1]++;
        mem_model[2] = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("collision count", 64'(cnt_b), 64'(16'(exp_cnt[1])));
        run_req(1, 32'h0000_0008, 3, {32'hC0DE_0003, 32'hDEAD_BEEF}, "collision new data");

        // Randomized requests against the image model, with random loads and aborts
        for (int n = 0; n < 40; n++) begin
            idx = int'($urandom_range(0, 1));
            lat = lat_of(idx);
            if ($urandom_range(0, 1) == 1) load_word($urandom, $urandom);
            a = $urandom;
            abort = ($urandom_range(0, 2) == 0);
            kab = int'($urandom_range(1, lat + 2));
            pulses = 0; pk = -1; pd = '0;
            @(negedge clk);
            set_req(idx, 1'b1, a);
            for (int k = 1; k <= lat + 6; k++) begin
                @(negedge clk);
                if (rx_of(idx)) begin
                    pulses++;
                    if (pulses == 1) begin
                        pk = k; pd = fd_of(idx);
                    end
                    set_req(idx, 1'b0, a);
                end
                if (abort && k == kab) set_req(idx, 1'b0, a);
            end
            set_req(idx, 1'b0, a);
            if (abort) begin
                chk($sformatf("rand%0d abort pulses", n), 64'(pulses), 64'd0);
            end else begin
                exp_cnt[idx]++;
                chk($sformatf("rand%0d pulses", n), 64'(pulses), 64'd1);
                chk($sformatf("rand%0d cycle", n), 64'(pk), 64'(lat + 3));
                chk($sformatf("rand%0d data", n), pd, model_line(a));
            end
            chk($sformatf("rand%0d count", n), 64'(cnt_of(idx)), 64'(16'(exp_cnt[idx])));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
